// File: rtl/event_pulse_generator_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : event_pulse_generator_pkg
//  Description : Shared types and constants for the event pulse generator:
//                FSM state encoding and a small compile-time helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package event_pulse_generator_pkg;

  // 2-bit state encoding; the enum below is bound to these values so the
  // encoding stays visible in waveforms and netlists.
  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_HIGH = 2'd1;
  localparam logic [1:0] c_ST_GAP  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = c_ST_IDLE,
    ST_HIGH = c_ST_HIGH,
    ST_GAP  = c_ST_GAP
  } state_t;

  // Elaboration-time maximum, used to size the shared phase counter.
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_updown_counter
//  Description : Saturating up/down counter. A simultaneous increment and
//                decrement cancel out. An increment that cannot be absorbed
//                (counter at max, no decrement) is flagged on o_drop.
//                i_clear restarts the count; a clear coinciding with an
//                increment loads 1 so that event is not lost.
//  Ports       : clk, reset (sync, active-high), i_clear, i_inc, i_dec,
//                o_count [WIDTH-1:0], o_drop
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_updown_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [WIDTH-1:0] o_count,
  output logic             o_drop
);

  localparam logic [WIDTH-1:0] c_MAX = '1;
  localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_count;
  logic             w_sat;

  assign w_sat   = (r_count == c_MAX);
  assign o_drop  = i_inc && !i_dec && w_sat;
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= i_inc ? c_ONE : '0;
    end else if (i_inc && !i_dec && !w_sat) begin
      r_count <= r_count + c_ONE;
    end else if (i_dec && !i_inc && (r_count != '0)) begin
      r_count <= r_count - c_ONE;
    end
  end

endmodule
`default_nettype wire

// File: rtl/event_pulse_generator.sv
`default_nettype none
// ============================================================================
//  Module      : event_pulse_generator
//  Description : Turns single-cycle event strobes into clean level pulses of
//                HIGH_CYCLES width separated by at least GAP_CYCLES low.
//                Events arriving during a pulse or gap are queued in a
//                saturating pending counter and replayed back-to-back.
//  Ports       : clk, reset (sync, active-high), event_in, clear_overflow,
//                pulse_out, busy, pending [PEND_W-1:0], overflow,
//                drop_count [7:0] (only with the optional feature)
//  Options     : EVENT_PULSE_GENERATOR_DROP_CNT_EN adds drop_count, a
//                saturating count of dropped events cleared by
//                clear_overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module event_pulse_generator
  import event_pulse_generator_pkg::*;
#(
  parameter int HIGH_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int PEND_W      = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              event_in,
  input  logic              clear_overflow,
  output logic              pulse_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
`ifdef EVENT_PULSE_GENERATOR_DROP_CNT_EN
  ,
  output logic [7:0]        drop_count
`endif
);

  localparam int c_PH_W = $clog2(max2(HIGH_CYCLES, GAP_CYCLES) + 1);
  localparam logic [c_PH_W-1:0] c_HIGH_LAST = c_PH_W'(HIGH_CYCLES - 1);
  localparam logic [c_PH_W-1:0] c_GAP_LAST  = c_PH_W'(GAP_CYCLES - 1);
  localparam logic [c_PH_W-1:0] c_PH_ONE    = c_PH_W'(1);

  state_t              r_state;
  logic [c_PH_W-1:0]   r_phase;
  logic                r_pulse;
  logic                r_overflow;

  logic [PEND_W-1:0]   w_pending;
  logic                w_pend_nz;
  logic                w_gap_end;
  logic                w_inc;
  logic                w_dec;
  logic                w_drop;

  assign w_pend_nz = |w_pending;
  assign w_gap_end = (r_state == ST_GAP) && (r_phase == c_GAP_LAST);

  // A queued event is consumed when a gap ends with work pending. A new
  // event at a gap end with nothing queued is consumed directly by the FSM
  // (GAP -> HIGH), so it never enters the queue.
  assign w_dec = w_gap_end && w_pend_nz;
  assign w_inc = event_in && (r_state != ST_IDLE) && !(w_gap_end && !w_pend_nz);

  sat_updown_counter #(
    .WIDTH (PEND_W)
  ) u_pending (
    .clk     (clk),
    .reset   (reset),
    .i_clear (1'b0),
    .i_inc   (w_inc),
    .i_dec   (w_dec),
    .o_count (w_pending),
    .o_drop  (w_drop)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_phase <= '0;
      r_pulse <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (event_in) begin
            r_state <= ST_HIGH;
            r_phase <= '0;
            r_pulse <= 1'b1;
          end
        end
        ST_HIGH: begin
          if (r_phase == c_HIGH_LAST) begin
            r_state <= ST_GAP;
            r_phase <= '0;
            r_pulse <= 1'b0;
          end else begin
            r_phase <= r_phase + c_PH_ONE;
          end
        end
        ST_GAP: begin
          if (r_phase == c_GAP_LAST) begin
            r_phase <= '0;
            if (w_pend_nz || event_in) begin
              r_state <= ST_HIGH;
              r_pulse <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_phase <= r_phase + c_PH_ONE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_phase <= '0;
          r_pulse <= 1'b0;
        end
      endcase
    end
  end

  // Sticky overflow: a drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (clear_overflow) begin
      r_overflow <= 1'b0;
    end
  end

`ifdef EVENT_PULSE_GENERATOR_DROP_CNT_EN
  logic w_dc_drop;

  sat_updown_counter #(
    .WIDTH (8)
  ) u_drop_count (
    .clk     (clk),
    .reset   (reset),
    .i_clear (clear_overflow),
    .i_inc   (w_drop),
    .i_dec   (1'b0),
    .o_count (drop_count),
    .o_drop  (w_dc_drop)
  );
`endif

  assign pulse_out = r_pulse;
  assign busy      = (r_state != ST_IDLE);
  assign pending   = w_pending;
  assign overflow  = r_overflow;

endmodule
`default_nettype wire
